trap_sequencer: RTL
===================

// Module: trap_sequencer
// PURPOSE
//  Sequences trap entry/exit for the CPU core from the irq_encoder outputs.
//  Latches cause, acks the encoder (deassert), saves EPC, masks IE, fetches handler vector, redirects PC.
//  Sits between irq_encoder, control register (IE bit), PC logic and memory bus.
// PARAMETERS
//  AW          16       address/PC width
//  VEC_BASE    16'hFF00 vector table base; entry n at VEC_BASE + n*VEC_STRIDE
//  VEC_STRIDE  2        vector entry spacing in address units
//  ACK_TMO     15       max cycles vec_req may wait for vec_ack before HALT
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, synchronous, active-high
//  trapnr      in   8   pending-trap bitmap from irq_encoder (bit0 = highest priority)
//  irq         in   1   encoder: interrupt pending (bits 2..5)
//  fault       in   1   encoder: fault pending (bits 0..1)
//  irq_en      in   1   IE bit of control register
//  instr_done  in   1   pulse: instruction retired this cycle (boundary)
//  cur_pc      in   AW  PC of faulting instr (fault) / next instr (irq)
//  reti        in   1   pulse: return-from-trap executed
//  vec_rdata   in   AW  vector read data, valid with vec_ack
//  vec_ack     in   1   bus ack for vector read
//  deassert    out  1   one-cycle pulse to encoder: clear lowest pending bit
//  cause       out  3   latched trap index (lowest set bit of trapnr)
//  epc_we      out  1   pulse: write epc_out to EPC register
//  epc_out     out  AW  value to save
//  ie_clear    out  1   pulse: clear IE
//  ie_restore  out  1   pulse: restore IE on return
//  stall       out  1   hold core pipeline
//  vec_req     out  1   vector read request
//  vec_addr    out  AW  VEC_BASE + cause*VEC_STRIDE (width AW, wraps mod 2^AW)
//  pc_load     out  1   pulse: load pc_next into PC
//  pc_next     out  AW  handler address
//  in_trap     out  1   handler executing
//  halted      out  1   sticky error: bus timeout or double fault
// BEHAVIOUR
//  Reset: state IDLE; every output 0; cause/epc_out/pc_next/vec_addr 0; timeout counter 0.
//  FSM states: IDLE, SAVE, FETCH, LOAD, HANDLER, HALT.
//  IDLE: fault=1 -> SAVE next edge, no boundary wait (faults abort instr).
//    else irq & irq_en & instr_done -> SAVE. irq with irq_en=0 stays pending in encoder.
//  SAVE (1 cycle): stall=1, deassert=1, epc_we=1, epc_out=cur_pc, ie_clear=1;
//    cause <= index of lowest set bit of trapnr (sampled this cycle). Encoder clears that
//    same bit at this edge; bits arriving this edge remain pending. -> FETCH.
//  FETCH: stall=1, vec_req=1, vec_addr stable until vec_ack. Capture vec_rdata on vec_ack -> LOAD.
//    Counter counts request cycles; ack absent after ACK_TMO cycles -> HALT.
//  LOAD (1 cycle): stall=1, pc_load=1, pc_next=captured vector -> HANDLER.
//  HANDLER: in_trap=1, stall=0. reti -> ie_restore pulse, -> IDLE.
//    irq ignored (IE cleared by SAVE). fault -> SAVE (nested; EPC overwritten).
//    fault and reti same cycle: fault wins, no ie_restore.
//  HALT: stall=1, halted=1, all pulses 0; exit only by reset.
//  Pulses (deassert, epc_we, ie_clear, ie_restore, pc_load) are exactly one cycle.
//  Trap entry latency: fault-to-pc_load = 3 cycles + vec_ack wait.
//  Reset mid-sequence: immediate return to IDLE, vec_req dropped same edge.
// CONFIGURATION
//  TRAP_DBL_FAULT_EN defined: fault while HANDLER and cause in {0,1} -> HALT (double fault),
//    no deassert, no EPC write. Fault while servicing an irq nests as normal.
//  Not defined: every fault in HANDLER nests via SAVE; HALT reachable only by bus timeout.
// STRUCTURE
//  trap_defs.vh: state encodings, cause indices (0 PROT, 1 PAGE, 2 UART, 3 DISK, 4 SYSCALL,
//    5 TIMER), VEC_BASE/VEC_STRIDE defaults.
//  Sub-module trap_cause_enc: combinational 8-bit lowest-set-bit -> 3-bit index (+valid).
// TESTING
//  trapnr=8'h04, irq=1, irq_en=1, instr_done=1, cur_pc=16'h0120, vec_rdata=16'h0400 ack after 2 cycles
//    -> deassert+epc_we(0120)+ie_clear in SAVE, vec_addr=FF04, pc_load with pc_next=0400, in_trap=1.
//  irq=1, irq_en=0 for 10 cycles -> stays IDLE, no deassert; raise irq_en -> entry on next instr_done.
//  trapnr=8'h22 (page + timer), fault=1 -> cause=1, vec_addr=FF02; after reti, timer entry cause=5, vec_addr=FF0A.
//  FETCH with vec_ack held 0 -> halted=1 after 15 request cycles; reset -> IDLE, outputs 0.
//  HANDLER (cause=1), fault with trapnr=8'h01 -> macro on: HALT, halted=1; off: SAVE, cause=0, EPC rewritten.
//  reset asserted in FETCH -> next cycle vec_req=0, stall=0, state IDLE; reti and fault same cycle -> SAVE, ie_restore=0.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// ============================================================================
// Module   : trap_sequencer_pkg
// Brief    : Shared types and defaults for the trap sequencer: FSM state
//            encoding, trap cause indices and vector table defaults.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package trap_sequencer_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_HANDLER = 3'd4,
        ST_HALT    = 3'd5
    } trap_state_e;

    // Trap cause indices (bit position in the encoder bitmap)
    typedef enum logic [2:0] {
        CAUSE_PROT    = 3'd0,
        CAUSE_PAGE    = 3'd1,
        CAUSE_UART    = 3'd2,
        CAUSE_DISK    = 3'd3,
        CAUSE_SYSCALL = 3'd4,
        CAUSE_TIMER   = 3'd5
    } trap_cause_e;

    // Vector table and bus defaults
    localparam int unsigned AW_DEFAULT         = 16;
    localparam logic [15:0] VEC_BASE_DEFAULT   = 16'hFF00;
    localparam int unsigned VEC_STRIDE_DEFAULT = 2;
    localparam int unsigned ACK_TMO_DEFAULT    = 15;

    // Causes 0 and 1 are synchronous faults; the rest are interrupts
    function automatic logic is_fault_cause(input logic [2:0] cause);
        return (cause == CAUSE_PROT) || (cause == CAUSE_PAGE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_sequencer_cause_enc.sv
// ============================================================================
// Module   : trap_cause_enc
// Brief    : Combinational lowest-set-bit encoder. Bit 0 of the pending
//            bitmap is the highest priority trap.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trap_cause_enc (
    input  logic [7:0] trapnr_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx_o   = 3'd0;
        valid_o = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (trapnr_i[i]) begin
                idx_o   = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/trap_sequencer.sv
// ============================================================================
// Module   : trap_sequencer
// Brief    : Trap entry/exit sequencer. Latches the trap cause, acks the
//            encoder, saves EPC, masks IE, fetches the handler vector over
//            the memory bus and redirects the PC. Returns on reti.
//            Optional feature macro: TRAP_DBL_FAULT_EN -- a fault raised
//            while servicing a fault halts the core (double fault).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned       AW         = AW_DEFAULT,
    parameter logic [AW-1:0]     VEC_BASE   = AW'(VEC_BASE_DEFAULT),
    parameter int unsigned       VEC_STRIDE = VEC_STRIDE_DEFAULT,
    parameter int unsigned       ACK_TMO    = ACK_TMO_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    trapnr,
    input  logic          irq,
    input  logic          fault,
    input  logic          irq_en,
    input  logic          instr_done,
    input  logic [AW-1:0] cur_pc,
    input  logic          reti,
    input  logic [AW-1:0] vec_rdata,
    input  logic          vec_ack,
    output logic          deassert,
    output logic [2:0]    cause,
    output logic          epc_we,
    output logic [AW-1:0] epc_out,
    output logic          ie_clear,
    output logic          ie_restore,
    output logic          stall,
    output logic          vec_req,
    output logic [AW-1:0] vec_addr,
    output logic          pc_load,
    output logic [AW-1:0] pc_next,
    output logic          in_trap,
    output logic          halted
);

    // Timeout counter counts completed request cycles 0..ACK_TMO-1
    localparam int unsigned TW       = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);

    trap_state_e   state_q,    state_d;
    logic [2:0]    cause_q,    cause_d;
    logic [AW-1:0] vec_addr_q, vec_addr_d;
    logic [AW-1:0] pc_next_q,  pc_next_d;
    logic [TW-1:0] tmo_q,      tmo_d;

    logic [2:0]    enc_idx;
    logic          enc_valid;
    logic [2:0]    save_idx;

    trap_cause_enc u_cause_enc (
        .trapnr_i (trapnr),
        .idx_o    (enc_idx),
        .valid_o  (enc_valid)
    );

    // An empty bitmap in SAVE keeps the previous cause rather than inventing 0
    assign save_idx = enc_valid ? enc_idx : cause_q;

    // State and datapath registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cause_q    <= 3'd0;
            vec_addr_q <= '0;
            pc_next_q  <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            vec_addr_q <= vec_addr_d;
            pc_next_q  <= pc_next_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        vec_addr_d = vec_addr_q;
        pc_next_d  = pc_next_q;
        tmo_d      = tmo_q;
        deassert   = 1'b0;
        epc_we     = 1'b0;
        epc_out    = '0;
        ie_clear   = 1'b0;
        ie_restore = 1'b0;
        stall      = 1'b0;
        vec_req    = 1'b0;
        pc_load    = 1'b0;
        in_trap    = 1'b0;
        halted     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Faults abort the current instruction; irqs wait for a boundary
                if (fault) begin
                    state_d = ST_SAVE;
                end else if (irq && irq_en && instr_done) begin
                    state_d = ST_SAVE;
                end
            end

            ST_SAVE: begin
                stall      = 1'b1;
                deassert   = 1'b1;
                epc_we     = 1'b1;
                epc_out    = cur_pc;
                ie_clear   = 1'b1;
                cause_d    = save_idx;
                vec_addr_d = VEC_BASE + AW'(VEC_STRIDE * 32'(save_idx));
                tmo_d      = '0;
                state_d    = ST_FETCH;
            end

            ST_FETCH: begin
                stall   = 1'b1;
                vec_req = 1'b1;
                if (vec_ack) begin
                    pc_next_d = vec_rdata;
                    state_d   = ST_LOAD;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_LOAD: begin
                stall   = 1'b1;
                pc_load = 1'b1;
                state_d = ST_HANDLER;
            end

            ST_HANDLER: begin
                // irq is ignored here: IE was cleared on entry
                in_trap = 1'b1;
                if (fault) begin
`ifdef TRAP_DBL_FAULT_EN
                    if (is_fault_cause(cause_q)) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_SAVE;
                    end
`else
                    state_d = ST_SAVE;
`endif
                end else if (reti) begin
                    ie_restore = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            ST_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cause    = cause_q;
    assign vec_addr = vec_addr_q;
    assign pc_next  = pc_next_q;

endmodule

`default_nettype wire
